// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet injector: packet type codes,
// packet field positions and the handshake FSM state encoding.
package noc_pkg;

  localparam int PKT_W = 32;

  localparam logic [2:0] PKT_FILTER = 3'b000;
  localparam logic [2:0] PKT_IFMAP  = 3'b001;
  localparam logic [2:0] PKT_PSUM   = 3'b010;

  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 29;
  localparam int DST_MSB  = 28;
  localparam int DST_LSB  = 21;
  localparam int SRC_MSB  = 20;
  localparam int SRC_LSB  = 13;
  localparam int DATA_MSB = 12;
  localparam int DATA_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    REQ_HI,
    REQ_LO
  } inj_state_t;

endpackage

// File: rtl/noc_pkt_injector_if.sv
// PE-side valid/ready port plus the 4-phase bundled-data channel toward
// the router. master = the injector, slave = the PE/router environment.
interface noc_pkt_injector_if;
  import noc_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_type;
  logic [7:0]       in_dst;
  logic [12:0]      in_data;
  logic             pkt_req;
  logic [PKT_W-1:0] pkt_data;
  logic             pkt_ack;

  modport master (
    input  in_valid, in_type, in_dst, in_data, pkt_ack,
    output in_ready, pkt_req, pkt_data
  );

  modport slave (
    output in_valid, in_type, in_dst, in_data, pkt_ack,
    input  in_ready, pkt_req, pkt_data
  );

endinterface

// File: rtl/pkt_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
// Writes when full and reads when empty are ignored.
module pkt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  // Power-of-two depth: the count MSB alone marks full.
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/noc_pkt_injector.sv
// PE-side packet injector: stamps payloads with this node's address, queues
// them, and sends each one over the router's 4-phase local_in channel.
module noc_pkt_injector
  import noc_pkg::*;
#(
  parameter int         WIDTH_PKT   = 32,
  parameter logic [2:0] ADDRX       = 3'd0,
  parameter logic [4:0] ADDRY       = 5'd0,
  parameter int         DEPTH       = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_pkt_injector_if.master    io,
  output logic                  busy,
  output logic [15:0]           sent_cnt
);

  logic [WIDTH_PKT-1:0]       wr_pkt, head_pkt;
  logic                       fifo_full, fifo_empty, pop;
  logic [$clog2(DEPTH):0]     fifo_count;

  logic [SYNC_STAGES-1:0]     ack_sync_q, ack_sync_d;
  logic                       ack_s;

  inj_state_t                 state_q, state_d;
  logic                       pkt_req_q, pkt_req_d;
  logic [WIDTH_PKT-1:0]       pkt_data_q, pkt_data_d;
  logic [15:0]                sent_cnt_q, sent_cnt_d;

  // The packet is assembled as it enters the FIFO.
  always_comb begin
    wr_pkt                    = '0;
    wr_pkt[TYPE_MSB:TYPE_LSB] = io.in_type;
    wr_pkt[DST_MSB:DST_LSB]   = io.in_dst;
    wr_pkt[SRC_MSB:SRC_LSB]   = {ADDRY, ADDRX};
    wr_pkt[DATA_MSB:DATA_LSB] = io.in_data;
  end

  pkt_fifo #(
    .WIDTH (WIDTH_PKT),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (io.in_valid),
    .wr_data (wr_pkt),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (head_pkt),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign io.in_ready = ~fifo_full;

  // pkt_ack comes from the router's clock domain; only ack_s is used below.
  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], io.pkt_ack};
  assign ack_s      = ack_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync_q <= '0;
    else        ack_sync_q <= ack_sync_d;
  end

  // ack_s seen in IDLE or SETUP is a protocol error and is deliberately ignored.
  always_comb begin
    state_d    = state_q;
    pkt_req_d  = pkt_req_q;
    pkt_data_d = pkt_data_q;
    sent_cnt_d = sent_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          pkt_data_d = head_pkt;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        pkt_req_d = 1'b1;
        state_d   = REQ_HI;
      end
      REQ_HI: begin
        if (ack_s) begin
          pkt_req_d = 1'b0;
          state_d   = REQ_LO;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          sent_cnt_d = sent_cnt_q + 16'd1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            pkt_data_d = head_pkt;
            state_d    = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pkt_req_q  <= 1'b0;
      pkt_data_q <= '0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_req_q  <= pkt_req_d;
      pkt_data_q <= pkt_data_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  assign io.pkt_req  = pkt_req_q;
  assign io.pkt_data = pkt_data_q;
  assign sent_cnt    = sent_cnt_q;
  assign busy        = (fifo_count != '0) | (state_q != IDLE);

endmodule

// File: tb/tb_noc_pkt_injector.sv
// Bench for noc_pkt_injector: vector table, directed handshake sequences and
// randomized traffic against a queue-based model with a router-side responder.
module tb_noc_pkt_injector;
  import noc_pkg::*;

  localparam logic [2:0] AX = 3'd2;
  localparam logic [4:0] AY = 5'd13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic [15:0] sent_cnt;

  always #5 clk = ~clk;

  noc_pkt_injector_if io();

  noc_pkt_injector #(
    .WIDTH_PKT   (32),
    .ADDRX       (AX),
    .ADDRY       (AY),
    .DEPTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io       (io),
    .busy     (busy),
    .sent_cnt (sent_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] build(input logic [2:0] t, input logic [7:0] d, input logic [12:0] p);
    return {t, d, AY, AX, p};
  endfunction

  // Model state and router-side responder
  logic [31:0] exp_q[$];
  logic [31:0] rcv_q[$];
  logic        prev_req, prev_ack, holding, auto_ack, man_ack;
  logic [31:0] hold_val;
  bit          auto_mode, rand_dly;
  int          rise_dly, fall_dly, rs, rcnt;
  int          viol     = 0;
  int          done_cnt = 0;

  initial begin
    io.pkt_ack = 1'b0;
    prev_req = 1'b0; prev_ack = 1'b0; holding = 1'b0; auto_ack = 1'b0;
    rs = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_req = 1'b0; prev_ack = 1'b0; holding = 1'b0; auto_ack = 1'b0;
        rs = 0; done_cnt = 0;
      end else begin
        if (io.pkt_req && !prev_req) begin
          if (io.pkt_ack) viol++;
          rcv_q.push_back(io.pkt_data);
          hold_val = io.pkt_data;
          holding  = 1'b1;
        end
        if (holding && io.pkt_data !== hold_val) viol++;
        if (prev_req && !io.pkt_req && !io.pkt_ack) viol++;
        if (prev_ack && !io.pkt_ack && holding) begin
          holding = 1'b0;
          done_cnt++;
        end
        prev_req = io.pkt_req;
        prev_ack = io.pkt_ack;
        if (auto_mode) begin
          case (rs)
            0: if (io.pkt_req) begin
                 rcnt = rand_dly ? int'($urandom_range(0, 4)) : rise_dly;
                 rs   = 1;
               end
            1: if (rcnt == 0) begin auto_ack = 1'b1; rs = 2; end
               else rcnt--;
            2: if (!io.pkt_req) begin
                 rcnt = rand_dly ? int'($urandom_range(0, 4)) : fall_dly;
                 rs   = 3;
               end
            default: if (rcnt == 0) begin auto_ack = 1'b0; rs = 0; end
                     else rcnt--;
          endcase
        end
      end
      io.pkt_ack = auto_mode ? auto_ack : man_ack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  task automatic drive(input logic [2:0] t, input logic [7:0] d, input logic [12:0] p, input logic v);
    io.in_valid = v;
    io.in_type  = t;
    io.in_dst   = d;
    io.in_data  = p;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || io.pkt_ack) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check({name, " idle"}, {31'd0, busy | io.pkt_ack}, 32'd0);
  endtask

  task automatic wait_req(input string name);
    int k = 0;
    while (!io.pkt_req && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, " req"}, {31'd0, io.pkt_req}, 32'd1);
  endtask

  task automatic compare_queues(input string name);
    check({name, " count"}, 32'(rcv_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rcv_q.size() > 0)
      check({name, " pkt"}, rcv_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    rcv_q.delete();
  endtask

  typedef struct {
    logic [2:0]  ptype;
    logic [7:0]  dst;
    logic [12:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vec[5];

  initial begin
    logic [31:0] pa, pb;
    logic        ok;
    logic [2:0]  rt;
    logic [7:0]  rd;
    logic [12:0] rp;
    logic        rv;

    vec[0] = '{PKT_IFMAP,  8'h6A, 13'd57,     32'h2D4D_4039};
    vec[1] = '{PKT_PSUM,   8'hFF, 13'h1FFF,   32'h5FED_5FFF};
    vec[2] = '{3'b111,     8'h00, 13'h0000,   32'hE00D_4000};
    vec[3] = '{PKT_FILTER, 8'h25, 13'h0ABC,   32'h04AD_4ABC};
    vec[4] = '{3'b011,     8'h81, 13'h1001,   32'h702D_5001};

    drive(3'd0, 8'd0, 13'd0, 1'b0);
    man_ack = 1'b0; auto_mode = 1'b0; rand_dly = 1'b0; rise_dly = 0; fall_dly = 0;
    rst_n = 1'b0;
    #3;
    check("reset pkt_req",  {31'd0, io.pkt_req}, 32'd0);
    check("reset pkt_data", io.pkt_data, 32'd0);
    check("reset sent_cnt", {16'd0, sent_cnt}, 32'd0);
    check("reset busy",     {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", {31'd0, io.in_ready}, 32'd1);

    // Vector table: 3-cycle latency to pkt_req and packet formatting
    auto_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vec[i].ptype, vec[i].dst, vec[i].data, 1'b1);
      check("vec in_ready", {31'd0, io.in_ready}, 32'd1);
      exp_q.push_back(vec[i].exp);
      @(negedge clk);
      io.in_valid = 1'b0;
      check("vec req after write", {31'd0, io.pkt_req}, 32'd0);
      @(negedge clk);
      check("vec pkt_data", io.pkt_data, vec[i].exp);
      check("vec req in setup", {31'd0, io.pkt_req}, 32'd0);
      @(negedge clk);
      check("vec req raised", {31'd0, io.pkt_req}, 32'd1);
      wait_idle("vec");
      check("vec sent_cnt", {16'd0, sent_cnt}, 32'(16'(done_cnt)));
    end
    compare_queues("table");

    // Back-to-back fill with acks held off
    auto_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rt = 3'($urandom); rd = 8'($urandom); rp = 13'($urandom);
      drive(rt, rd, rp, 1'b1);
      check("b2b in_ready", {31'd0, io.in_ready}, 32'd1);
      exp_q.push_back(build(rt, rd, rp));
      @(negedge clk);
    end
    drive(3'd5, 8'h11, 13'h0777, 1'b1);
    check("b2b full", {31'd0, io.in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    check("b2b still full", {31'd0, io.in_ready}, 32'd0);
    check("b2b busy", {31'd0, busy}, 32'd1);
    io.in_valid = 1'b0;
    rise_dly = 1;
    auto_mode = 1'b1;
    wait_idle("b2b");
    compare_queues("b2b");
    check("b2b sent_cnt", {16'd0, sent_cnt}, 32'(16'(done_cnt)));

    // Slow ack: req held until ack_s rises, data held until ack_s falls
    auto_mode = 1'b0;
    pa = build(PKT_PSUM, 8'h3C, 13'h0155);
    pb = build(PKT_IFMAP, 8'hC3, 13'h1AAA);
    drive(PKT_PSUM, 8'h3C, 13'h0155, 1'b1);
    exp_q.push_back(pa);
    @(negedge clk);
    drive(PKT_IFMAP, 8'hC3, 13'h1AAA, 1'b1);
    exp_q.push_back(pb);
    @(negedge clk);
    io.in_valid = 1'b0;
    wait_req("slow");
    ok = 1'b1;
    repeat (7) begin
      @(negedge clk);
      ok &= io.pkt_req;
    end
    check("slow req held w/o ack", {31'd0, ok}, 32'd1);
    man_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("slow req held during sync", {31'd0, io.pkt_req}, 32'd1);
    @(negedge clk);
    check("slow req dropped", {31'd0, io.pkt_req}, 32'd0);
    repeat (3) @(negedge clk);
    check("slow data held in REQ_LO", io.pkt_data, pa);
    man_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("slow data before ack_s falls", io.pkt_data, pa);
    check("slow sent before ack_s falls", {16'd0, sent_cnt}, 32'(16'(done_cnt - 1)));
    @(negedge clk);
    check("slow next data", io.pkt_data, pb);
    check("slow sent after ack_s falls", {16'd0, sent_cnt}, 32'(16'(done_cnt)));
    rise_dly = 0;
    auto_mode = 1'b1;
    wait_idle("slow");
    compare_queues("slow");

    // Spurious ack while IDLE
    auto_mode = 1'b0;
    man_ack = 1'b1;
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      ok &= ~io.pkt_req & ~busy;
    end
    man_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ok &= ~io.pkt_req & ~busy;
    end
    check("spurious ack ignored", {31'd0, ok}, 32'd1);
    check("spurious sent_cnt", {16'd0, sent_cnt}, 32'(16'(done_cnt)));
    check("spurious no packet", 32'(rcv_q.size()), 32'd0);

    // Reset in REQ_HI with two packets queued
    for (int i = 0; i < 3; i++) begin
      drive(PKT_FILTER, 8'(i), 13'(i + 100), 1'b1);
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    wait_req("rst mid");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid pkt_req",  {31'd0, io.pkt_req}, 32'd0);
    check("rst mid busy",     {31'd0, busy}, 32'd0);
    check("rst mid in_ready", {31'd0, io.in_ready}, 32'd1);
    check("rst mid sent_cnt", {16'd0, sent_cnt}, 32'd0);
    exp_q.delete();
    rcv_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      ok &= ~io.pkt_req;
    end
    check("rst mid nothing emitted", {31'd0, ok}, 32'd1);
    check("rst mid no capture", 32'(rcv_q.size()), 32'd0);
    check("rst mid idle", {31'd0, busy}, 32'd0);

    // Randomized traffic with random ack delays
    rand_dly = 1'b1;
    auto_mode = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rv = ($urandom_range(0, 9) < 6);
      rt = 3'($urandom); rd = 8'($urandom); rp = 13'($urandom);
      drive(rt, rd, rp, rv);
      if (rv && io.in_ready) exp_q.push_back(build(rt, rd, rp));
      @(negedge clk);
    end
    io.in_valid = 1'b0;
    wait_idle("random");
    compare_queues("random");
    check("random sent_cnt", {16'd0, sent_cnt}, 32'(16'(done_cnt)));
    check("protocol violations", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
